// File: rtl/iter_divider.sv
// Radix-2 non-restoring iterative divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qsh;
    logic [WIDTH-1:0] dvs;
    logic             neg_a;
    logic             neg_b;
    logic             sgn;

    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             zero_in;
    logic             ovf_in;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;

    always_comb begin
        a_neg_in = is_signed & dividend[WIDTH-1];
        b_neg_in = is_signed & divisor[WIDTH-1];
        a_mag    = a_neg_in ? -dividend : dividend;
        b_mag    = b_neg_in ? -divisor : divisor;
        zero_in  = (divisor == '0);
        ovf_in   = is_signed
                 && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                 && (divisor == '1);
        accept   = (state == IDLE) && in_valid && !flush;
        last     = (cnt == CW'(WIDTH-1));
    end

    // Partial remainder is WIDTH+1 bits; wraparound of the shifted
    // intermediate is harmless because every step result lies in [-D, D).
    always_comb begin
        rem_sh  = {prem[WIDTH-1:0], qsh[WIDTH-1]};
        rem_nx  = prem[WIDTH] ? rem_sh + {1'b0, dvs}
                              : rem_sh - {1'b0, dvs};
        q_nx    = {qsh[WIDTH-2:0], ~rem_nx[WIDTH]};
        rem_fix = rem_nx[WIDTH-1:0] + (rem_nx[WIDTH] ? dvs : '0);
        q_out   = (sgn && (neg_a ^ neg_b)) ? -q_nx : q_nx;
        r_out   = (sgn && neg_a) ? -rem_fix : rem_fix;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = (zero_in || ovf_in) ? DONE : BUSY;
            end
            BUSY: begin
                if (flush)
                    state_nx = IDLE;
                else if (last)
                    state_nx = DONE;
            end
            DONE: begin
                if (flush || out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prem        <= '0;
            qsh         <= '0;
            dvs         <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            sgn         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                neg_a <= a_neg_in;
                neg_b <= b_neg_in;
                sgn   <= is_signed;
                dvs   <= b_mag;
                qsh   <= a_mag;
                prem  <= '0;
                cnt   <= '0;
                if (zero_in) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else if (ovf_in) begin
                    quotient    <= dividend;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                end
            end else if ((state == BUSY) && !flush) begin
                prem <= rem_nx;
                qsh  <= q_nx;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    quotient    <= q_out;
                    remainder   <= r_out;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
